// File: rtl/cpu_mon_pkg.sv
// Status codes and FSM encoding shared by the CPU run monitor.
package cpu_mon_pkg;

   localparam logic [2:0] ST_RUNNING = 3'd0;
   localparam logic [2:0] ST_PASS    = 3'd1;
   localparam logic [2:0] ST_FAIL    = 3'd2;
   localparam logic [2:0] ST_TIMEOUT = 3'd3;
   localparam logic [2:0] ST_HALTED  = 3'd4;

   typedef enum logic {
      S_RUN = 1'b0,
      S_FIN = 1'b1
   } state_e;

endpackage

// File: rtl/cpu_run_monitor_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
// Latency 1 cycle from EN to Q, no backpressure.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         EN,
   output logic [W-1:0] Q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (EN && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign Q = cnt_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Watches CPU PC/instruction/data-memory handshake, gathers run statistics and latches end-of-test status.
// Latency 1 cycle from the qualifying input cycle to DONE/STATUS; purely observing, no backpressure.
module cpu_run_monitor
   import cpu_mon_pkg::*;
#(
   parameter int               XLEN           = 32,
   parameter int               CNT_W          = 32,
   parameter logic [XLEN-1:0]  TOHOST_ADDR    = 32'h0000_1000,
   parameter logic [XLEN-1:0]  PASS_VALUE     = 32'h0000_0001,
   parameter logic [XLEN-1:0]  HALT_INSTR     = 32'h0000_006F,
   parameter int               HALT_CYCLES    = 8,
   parameter int               TIMEOUT_CYCLES = 50
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [XLEN-1:0]   PC,
   input  logic [XLEN-1:0]   INSTRUCTION,
   input  logic              BUSYWAIT,
   input  logic              MEM_READ,
   input  logic              MEM_WRITE,
   input  logic [XLEN-1:0]   MEM_ADDRESS,
   input  logic [XLEN-1:0]   MEM_WRITE_DATA,
   output logic              DONE,
   output logic [2:0]        STATUS,
   output logic [CNT_W-1:0]  CYCLE_COUNT,
   output logic [CNT_W-1:0]  STALL_COUNT,
   output logic [CNT_W-1:0]  RD_COUNT,
   output logic [CNT_W-1:0]  WR_COUNT,
   output logic [CNT_W-1:0]  PC_CHANGES,
   output logic [XLEN-1:0]   TOHOST_DATA,
   output logic [XLEN-1:0]   FINAL_PC
);

   localparam int HC_W  = $clog2(HALT_CYCLES + 1);
   // Wide enough that neither a narrow counter nor a large limit is truncated in the compare.
   localparam int CMP_W = CNT_W + 32;

   state_e            state_q,    state_d;
   logic [2:0]        status_q,   status_d;
   logic [XLEN-1:0]   tohost_q,   tohost_d;
   logic [XLEN-1:0]   final_pc_q, final_pc_d;
   logic [HC_W-1:0]   halt_cnt_q, halt_cnt_d;
   logic [XLEN-1:0]   prev_pc_q;
   logic              prev_vld_q;

   logic run;
   logic rd_done;
   logic wr_done;
   logic pc_chg;
   logic halt_qual;
   logic tohost_hit;
   logic halt_hit;
   logic timeout_hit;

   assign run         = (state_q == S_RUN);
   assign rd_done     = MEM_READ  && !BUSYWAIT;
   assign wr_done     = MEM_WRITE && !BUSYWAIT;
   assign pc_chg      = prev_vld_q && (PC != prev_pc_q);
   assign halt_qual   = prev_vld_q && (PC == prev_pc_q) && (INSTRUCTION == HALT_INSTR);
   assign tohost_hit  = wr_done && (MEM_ADDRESS == TOHOST_ADDR);
   assign halt_hit    = halt_qual && (halt_cnt_q == HC_W'(HALT_CYCLES - 1));
   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        (CMP_W'(CYCLE_COUNT) == CMP_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      status_d   = status_q;
      tohost_d   = tohost_q;
      final_pc_d = final_pc_q;
      halt_cnt_d = halt_cnt_q;
      if (run) begin
         if (!halt_qual) begin
            halt_cnt_d = '0;
         end else if (halt_cnt_q != HC_W'(HALT_CYCLES)) begin
            halt_cnt_d = halt_cnt_q + HC_W'(1);
         end
         // Priority: tohost > halt > timeout, so exactly one status is latched.
         if (tohost_hit) begin
            state_d    = S_FIN;
            status_d   = (MEM_WRITE_DATA == PASS_VALUE) ? ST_PASS : ST_FAIL;
            tohost_d   = MEM_WRITE_DATA;
            final_pc_d = PC;
         end else if (halt_hit) begin
            state_d    = S_FIN;
            status_d   = ST_HALTED;
            final_pc_d = PC;
         end else if (timeout_hit) begin
            state_d    = S_FIN;
            status_d   = ST_TIMEOUT;
            final_pc_d = PC;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_RUN;
         status_q   <= ST_RUNNING;
         tohost_q   <= '0;
         final_pc_q <= '0;
         halt_cnt_q <= '0;
         prev_pc_q  <= '0;
         prev_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         status_q   <= status_d;
         tohost_q   <= tohost_d;
         final_pc_q <= final_pc_d;
         halt_cnt_q <= halt_cnt_d;
         prev_pc_q  <= PC;
         prev_vld_q <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .CLK(CLK), .RESET(RESET), .EN(run), .Q(CYCLE_COUNT)
   );
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK(CLK), .RESET(RESET), .EN(run && BUSYWAIT), .Q(STALL_COUNT)
   );
   sat_counter #(.W(CNT_W)) u_rd_cnt (
      .CLK(CLK), .RESET(RESET), .EN(run && rd_done), .Q(RD_COUNT)
   );
   sat_counter #(.W(CNT_W)) u_wr_cnt (
      .CLK(CLK), .RESET(RESET), .EN(run && wr_done), .Q(WR_COUNT)
   );
   sat_counter #(.W(CNT_W)) u_pc_chg_cnt (
      .CLK(CLK), .RESET(RESET), .EN(run && pc_chg), .Q(PC_CHANGES)
   );

   assign DONE        = (state_q == S_FIN);
   assign STATUS      = status_q;
   assign TOHOST_DATA = tohost_q;
   assign FINAL_PC    = final_pc_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench: stimulus queues expected monitor state, a negedge monitor pops and compares.
module tb_cpu_run_monitor;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] HALT = 32'h0000_006F;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] PC, INSTRUCTION, MEM_ADDRESS, MEM_WRITE_DATA;
   logic        BUSYWAIT, MEM_READ, MEM_WRITE;

   logic        m_done, n_done, s_done;
   logic [2:0]  m_st, n_st, s_st;
   logic [31:0] m_cyc, m_stall, m_rd, m_wr, m_pcc, m_toh, m_fpc;
   logic [31:0] n_cyc, n_stall, n_rd, n_wr, n_pcc, n_toh, n_fpc;
   logic [3:0]  s_cyc, s_stall, s_rd, s_wr, s_pcc;
   logic [31:0] s_toh, s_fpc;

   always #5 CLK = ~CLK;

   cpu_run_monitor dut (
      .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITE_DATA(MEM_WRITE_DATA), .DONE(m_done), .STATUS(m_st), .CYCLE_COUNT(m_cyc),
      .STALL_COUNT(m_stall), .RD_COUNT(m_rd), .WR_COUNT(m_wr), .PC_CHANGES(m_pcc),
      .TOHOST_DATA(m_toh), .FINAL_PC(m_fpc)
   );

   cpu_run_monitor #(.TIMEOUT_CYCLES(0)) dut_nt (
      .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITE_DATA(MEM_WRITE_DATA), .DONE(n_done), .STATUS(n_st), .CYCLE_COUNT(n_cyc),
      .STALL_COUNT(n_stall), .RD_COUNT(n_rd), .WR_COUNT(n_wr), .PC_CHANGES(n_pcc),
      .TOHOST_DATA(n_toh), .FINAL_PC(n_fpc)
   );

   cpu_run_monitor #(.CNT_W(4)) dut_sat (
      .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITE_DATA(MEM_WRITE_DATA), .DONE(s_done), .STATUS(s_st), .CYCLE_COUNT(s_cyc),
      .STALL_COUNT(s_stall), .RD_COUNT(s_rd), .WR_COUNT(s_wr), .PC_CHANGES(s_pcc),
      .TOHOST_DATA(s_toh), .FINAL_PC(s_fpc)
   );

   typedef struct {
      int          tag;
      int          sel;      // 0 default, 1 watchdog disabled, 2 4-bit counters
      bit          on_done;  // compare when DONE rises instead of at the next sample
      logic        done;
      logic [2:0]  st;
      logic [31:0] cyc, stall, rd, wr, pcc, toh, fpc;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   next_tag = 0;

   function automatic exp_t sample(input int sel);
      exp_t a;
      a.tag = 0; a.sel = sel; a.on_done = 1'b0;
      case (sel)
         0: begin
            a.done = m_done; a.st = m_st; a.cyc = m_cyc; a.stall = m_stall;
            a.rd = m_rd; a.wr = m_wr; a.pcc = m_pcc; a.toh = m_toh; a.fpc = m_fpc;
         end
         1: begin
            a.done = n_done; a.st = n_st; a.cyc = n_cyc; a.stall = n_stall;
            a.rd = n_rd; a.wr = n_wr; a.pcc = n_pcc; a.toh = n_toh; a.fpc = n_fpc;
         end
         default: begin
            a.done = s_done; a.st = s_st; a.cyc = 32'(s_cyc); a.stall = 32'(s_stall);
            a.rd = 32'(s_rd); a.wr = 32'(s_wr); a.pcc = 32'(s_pcc); a.toh = s_toh; a.fpc = s_fpc;
         end
      endcase
      return a;
   endfunction

   task automatic check(input int tag, input string f, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL chk%0d.%s got 0x%0h expected 0x%0h", tag, f, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e, a;
      forever begin
         @(negedge CLK);
         while (exp_q.size() > 0) begin
            e = exp_q[0];
            a = sample(e.sel);
            if (e.on_done && a.done !== 1'b1) break;
            void'(exp_q.pop_front());
            check(e.tag, "done",     32'(a.done), 32'(e.done));
            check(e.tag, "status",   32'(a.st),   32'(e.st));
            check(e.tag, "cycles",   a.cyc,   e.cyc);
            check(e.tag, "stalls",   a.stall, e.stall);
            check(e.tag, "reads",    a.rd,    e.rd);
            check(e.tag, "writes",   a.wr,    e.wr);
            check(e.tag, "pc_chg",   a.pcc,   e.pcc);
            check(e.tag, "tohost",   a.toh,   e.toh);
            check(e.tag, "final_pc", a.fpc,   e.fpc);
         end
      end
   end

   task automatic expect_state(input int sel, input bit on_done, input logic done, input logic [2:0] st,
                               input logic [31:0] cyc, stall, rd, wr, pcc, toh, fpc);
      exp_t e;
      e.tag = next_tag; e.sel = sel; e.on_done = on_done; e.done = done; e.st = st;
      e.cyc = cyc; e.stall = stall; e.rd = rd; e.wr = wr; e.pcc = pcc; e.toh = toh; e.fpc = fpc;
      next_tag++;
      exp_q.push_back(e);
   endtask

   task automatic tick(input logic [31:0] pc, ins, input logic bw, rd, wr, input logic [31:0] addr, data);
      PC = pc; INSTRUCTION = ins; BUSYWAIT = bw; MEM_READ = rd; MEM_WRITE = wr;
      MEM_ADDRESS = addr; MEM_WRITE_DATA = data;
      @(posedge CLK);
      #1;
   endtask

   // Called 1 ns after a rising edge; the pulse straddles the falling edge but no rising edge.
   task automatic do_reset();
      PC = '0; INSTRUCTION = NOP; BUSYWAIT = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      MEM_ADDRESS = '0; MEM_WRITE_DATA = '0;
      #2;
      RESET = 1'b1;
      expect_state(0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      RESET = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(posedge CLK);
         #1;
         n++;
      end
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain_chk%0d got %0d pending expected 0 pending", exp_q[0].tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin : stimulus
      @(posedge CLK);
      #1;

      // Reset mid-run: reads, a stalled read, three stalls, then async reset and restart.
      do_reset();
      for (int k = 0; k < 7; k++)
         tick(32'(4 * k), NOP, (k >= 1 && k <= 3), (k == 2 || k == 4), 1'b0, 32'h0, 32'h0);
      expect_state(0, 1'b0, 1'b0, 3'd0, 7, 3, 1, 0, 6, 0, 0);
      drain(20);
      do_reset();
      for (int k = 0; k < 5; k++)
         tick(32'h100 + 32'(4 * k), NOP, 1'b0, 1'b0, (k == 2), 32'h2000, 32'h5);
      expect_state(0, 1'b0, 1'b0, 3'd0, 5, 0, 0, 1, 4, 0, 0);
      drain(20);

      // Pass via tohost after two stall cycles, then counters must stay frozen.
      do_reset();
      expect_state(0, 1'b1, 1'b1, 3'd1, 13, 2, 0, 1, 12, 32'h1, 32'h30);
      for (int k = 0; k < 10; k++) tick(32'(4 * k), NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(32'd40, NOP, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h1);
      tick(32'd44, NOP, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h1);
      tick(32'd48, NOP, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h1);
      for (int k = 13; k < 33; k++)
         tick(32'(4 * k), NOP, (k % 2 == 0), 1'b1, (k == 20), 32'h1000, 32'h3);
      expect_state(0, 1'b0, 1'b1, 3'd1, 13, 2, 0, 1, 12, 32'h1, 32'h30);
      drain(60);

      // Tohost fail on cycle 49 coinciding with halt and timeout.
      do_reset();
      expect_state(0, 1'b1, 1'b1, 3'd2, 50, 0, 0, 1, 41, 32'h3, 32'h200);
      for (int k = 0; k <= 40; k++) tick(32'(4 * k), NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 41; k <= 48; k++) tick(32'h200, HALT, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(32'h200, HALT, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h3);
      drain(60);

      // Halt self-loop from cycle 5: qualifying cycles 6..13.
      do_reset();
      expect_state(0, 1'b1, 1'b1, 3'd4, 14, 0, 0, 0, 5, 0, 32'h40);
      for (int k = 0; k < 5; k++) tick(32'(4 * k), NOP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 5; k < 21; k++) tick(32'h40, HALT, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drain(60);

      // Watchdog fires at 50; the disabled instance keeps running for 200 cycles.
      do_reset();
      expect_state(0, 1'b1, 1'b1, 3'd3, 50, 1, 1, 0, 49, 0, 32'hC4);
      for (int k = 0; k < 200; k++)
         tick(32'(4 * k), NOP, (k == 10), (k == 3), 1'b0, 32'h0, 32'h0);
      expect_state(1, 1'b0, 1'b0, 3'd0, 200, 1, 1, 0, 199, 0, 0);
      drain(60);

      // Saturation: 30 stalled cycles, 4-bit instance sticks at 15.
      do_reset();
      for (int k = 0; k < 30; k++) tick(32'(4 * k), NOP, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      expect_state(0, 1'b0, 1'b0, 3'd0, 30, 30, 0, 0, 29, 0, 0);
      expect_state(2, 1'b0, 1'b0, 3'd0, 15, 15, 0, 0, 15, 0, 0);
      drain(60);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
